// File: rtl/generic_sram_line_en_arbiter_pkg.sv
// Shared types and the round-robin pick function for the SRAM line-enable arbiter.
package generic_sram_line_en_arbiter_pkg;

  localparam int MAX_PORTS = 16;
  localparam int IDX_W     = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    ACK    = 2'd3
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req scanning upward from ptr, modulo n. Scanning from the
  // far end down lets the closest match overwrite earlier ones.
  function automatic rr_pick_t rr_pick(input logic [MAX_PORTS-1:0] req,
                                       input logic [IDX_W-1:0]     ptr,
                                       input int                   n);
    rr_pick_t r;
    int       j;
    r = '0;
    for (int k = MAX_PORTS-1; k >= 0; k--) begin
      if (k < n) begin
        j = (int'(ptr) + k) % n;
        if (req[j]) begin
          r.valid = 1'b1;
          r.idx   = IDX_W'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/generic_sram_line_en_rr_select.sv
// Combinational round-robin picker: request vector plus pointer in, winner out.
module generic_sram_line_en_rr_select
  import generic_sram_line_en_arbiter_pkg::*;
#(
  parameter  int NUM_PORTS = 4,
  localparam int PW        = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [PW-1:0]        ptr_i,
  output logic [PW-1:0]        winner_o,
  output logic                 valid_o
);

  rr_pick_t pick;

  always_comb begin
    pick     = rr_pick(MAX_PORTS'(req_i), IDX_W'(ptr_i), NUM_PORTS);
    winner_o = PW'(pick.idx);
    valid_o  = pick.valid;
  end

endmodule

// File: rtl/generic_sram_line_en_arbiter.sv
// Round-robin arbiter sharing one SRAM line-enable port among NUM_PORTS
// request/ack masters, one access in flight at a time.
module generic_sram_line_en_arbiter
  import generic_sram_line_en_arbiter_pkg::*;
#(
  parameter  int NUM_PORTS     = 4,
  parameter  int NUM_ADDR_BITS = 32,
  parameter  int NUM_DATA_BITS = 32,
  localparam int PW            = $clog2(NUM_PORTS)
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [NUM_PORTS-1:0]               req,
  input  logic [NUM_PORTS-1:0]               rnw,
  input  logic [NUM_PORTS*NUM_ADDR_BITS-1:0] addr,
  input  logic [NUM_PORTS*NUM_DATA_BITS-1:0] wdata,
  output logic [NUM_PORTS-1:0]               ack,
  output logic [NUM_DATA_BITS-1:0]           rdata,
  output logic                               busy,
  output logic [PW-1:0]                      grant_id,
  output logic [NUM_ADDR_BITS-1:0]           sram_addr,
  output logic [NUM_DATA_BITS-1:0]           sram_write_data,
  output logic                               sram_write_en,
  output logic                               sram_read_en,
  input  logic [NUM_DATA_BITS-1:0]           sram_read_data
);

  state_e                     state_q;
  logic [PW-1:0]              ptr_q, ptr_d, gid_q;
  logic [NUM_PORTS-1:0]       ack_q;
  logic [NUM_DATA_BITS-1:0]   rdata_q, wdata_q;
  logic [NUM_ADDR_BITS-1:0]   addr_q;
  logic                       wr_en_q, rd_en_q;
  logic [PW-1:0]              pick_w;
  logic                       pick_vld;

  generic_sram_line_en_rr_select #(.NUM_PORTS(NUM_PORTS)) u_sel (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (pick_w),
    .valid_o  (pick_vld)
  );

  assign ptr_d = (gid_q == PW'(NUM_PORTS-1)) ? '0 : gid_q + PW'(1);

  // rd_en_q doubles as the read/write flag while in ACCESS.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            gid_q  <= pick_w;
            addr_q <= addr[int'(pick_w)*NUM_ADDR_BITS +: NUM_ADDR_BITS];
            if (rnw[pick_w]) begin
              rd_en_q <= 1'b1;
            end else begin
              wr_en_q <= 1'b1;
              wdata_q <= wdata[int'(pick_w)*NUM_DATA_BITS +: NUM_DATA_BITS];
            end
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          rd_en_q <= 1'b0;
          wr_en_q <= 1'b0;
          addr_q  <= '0;
          wdata_q <= '0;
          if (rd_en_q) begin
            state_q <= WAIT;
          end else begin
            ack_q[gid_q] <= 1'b1;
            state_q      <= ACK;
          end
        end
        WAIT: begin
          rdata_q      <= sram_read_data;
          ack_q[gid_q] <= 1'b1;
          state_q      <= ACK;
        end
        ACK: begin
          ack_q   <= '0;
          ptr_q   <= ptr_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack             = ack_q;
  assign rdata           = rdata_q;
  assign busy            = (state_q != IDLE);
  assign grant_id        = gid_q;
  assign sram_addr       = addr_q;
  assign sram_write_data = wdata_q;
  assign sram_write_en   = wr_en_q;
  assign sram_read_en    = rd_en_q;

endmodule

// File: tb/tb_generic_sram_line_en_arbiter.sv
// Directed bench for generic_sram_line_en_arbiter with a one-cycle-latency SRAM model.
module tb_generic_sram_line_en_arbiter;

  localparam int NP = 4, AW = 32, DW = 32;

  logic            clk = 1'b0;
  logic            rstn;
  logic [NP-1:0]   req, rnw, ack;
  logic [NP*AW-1:0] addr;
  logic [NP*DW-1:0] wdata;
  logic [DW-1:0]   rdata, sram_write_data;
  logic [DW-1:0]   sram_read_data = '0;
  logic            busy, sram_write_en, sram_read_en;
  logic [1:0]      grant_id;
  logic [AW-1:0]   sram_addr;

  int checks = 0, errors = 0;

  logic [DW-1:0] mem [0:1023];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_write_en) mem[sram_addr[9:0]] <= sram_write_data;
    if (sram_read_en)  sram_read_data <= mem[sram_addr[9:0]];
  end

  generic_sram_line_en_arbiter #(.NUM_PORTS(NP), .NUM_ADDR_BITS(AW), .NUM_DATA_BITS(DW)) dut (
    .clk(clk), .rstn(rstn), .req(req), .rnw(rnw), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .grant_id(grant_id),
    .sram_addr(sram_addr), .sram_write_data(sram_write_data),
    .sram_write_en(sram_write_en), .sram_read_en(sram_read_en),
    .sram_read_data(sram_read_data)
  );

  int            got_id [16];
  int            got_gid[16];
  int            got_cyc[16];
  logic [DW-1:0] got_rd [16];
  int            n_got;
  bit            multi, both, tmo;

  task automatic set_port(input int p, input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rnw[p] = r;
    addr[p*AW +: AW] = a;
    wdata[p*DW +: DW] = d;
  endtask

  // Requester model: records each ack, drops acked req bits, re-raises sticky ones.
  task automatic run_acks(input int n, input logic [NP-1:0] sticky, input int budget);
    int cyc;
    n_got = 0; multi = 0; both = 0; tmo = 0; cyc = 0;
    while (n_got < n && !tmo) begin
      @(negedge clk);
      cyc++;
      if (sram_read_en && sram_write_en) both = 1;
      if (ack != '0) begin
        if ($countones(ack) != 1) multi = 1;
        for (int i = 0; i < NP; i++) if (ack[i]) got_id[n_got] = i;
        got_gid[n_got] = int'(grant_id);
        got_cyc[n_got] = cyc;
        got_rd[n_got]  = rdata;
        n_got++;
        req = (req & ~ack) | sticky;
      end
      if (cyc >= budget && n_got < n) tmo = 1;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; req = '0; rnw = '0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL reset_ack got %b exp 0", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_gid got %0d exp 0", grant_id); end
    checks++; if ({sram_write_en, sram_read_en} !== 2'b00) begin errors++; $display("FAIL reset_en got %b exp 00", {sram_write_en, sram_read_en}); end
    checks++; if (sram_addr !== '0 || sram_write_data !== '0 || rdata !== '0) begin errors++; $display("FAIL reset_data got %h/%h/%h exp 0", sram_addr, sram_write_data, rdata); end
    @(negedge clk); rstn = 1'b1;
  endtask

  task automatic test_write();
    @(posedge clk); #1;
    set_port(2, 1'b0, 32'h100, 32'hDEADBEEF); req = 4'b0100;
    @(posedge clk); #1;
    checks++; if ({sram_write_en, sram_read_en} !== 2'b10) begin errors++; $display("FAIL wr_en got %b exp 10", {sram_write_en, sram_read_en}); end
    checks++; if (sram_addr !== 32'h100 || sram_write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_bus got %h/%h exp 100/deadbeef", sram_addr, sram_write_data); end
    checks++; if (grant_id !== 2'd2 || busy !== 1'b1 || ack !== 4'b0) begin errors++; $display("FAIL wr_access got gid %0d busy %b ack %b exp 2 1 0000", grant_id, busy, ack); end
    @(posedge clk); #1;
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL wr_ack got %b exp 0100", ack); end
    checks++; if (sram_write_en !== 1'b0 || sram_addr !== '0 || sram_write_data !== '0) begin errors++; $display("FAIL wr_clear got %b %h %h exp 0 0 0", sram_write_en, sram_addr, sram_write_data); end
    req = '0;
    @(posedge clk); #1;
    checks++; if (ack !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL wr_done got ack %b busy %b exp 0000 0", ack, busy); end
    checks++; if (mem[10'h100] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_mem got %h exp deadbeef", mem[10'h100]); end
  endtask

  task automatic test_read();
    @(posedge clk); #1;
    set_port(2, 1'b1, 32'h100, 32'h0); req = 4'b0100;
    @(posedge clk); #1;
    checks++; if ({sram_write_en, sram_read_en} !== 2'b01 || sram_addr !== 32'h100) begin errors++; $display("FAIL rd_en got %b addr %h exp 01 100", {sram_write_en, sram_read_en}, sram_addr); end
    @(posedge clk); #1;
    checks++; if (ack !== 4'b0 || sram_read_en !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rd_wait got ack %b ren %b busy %b exp 0000 0 1", ack, sram_read_en, busy); end
    @(posedge clk); #1;
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL rd_ack got %b exp 0100", ack); end
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h exp deadbeef", rdata); end
    req = '0;
    @(posedge clk); #1;
    checks++; if (ack !== 4'b0 || rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_hold got ack %b rdata %h exp 0000 deadbeef", ack, rdata); end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    set_port(1, 1'b0, 32'h104, 32'h12345678); req = 4'b0010;
    run_acks(3, 4'b0010, 30);
    req = '0;
    checks++; if (tmo) begin errors++; $display("FAIL b2b_timeout got %0d acks exp 3", n_got); end
    checks++; if (got_id[0] != 1 || got_id[1] != 1 || got_id[2] != 1) begin errors++; $display("FAIL b2b_ids got %0d %0d %0d exp 1 1 1", got_id[0], got_id[1], got_id[2]); end
    checks++; if (got_cyc[1] - got_cyc[0] != 3 || got_cyc[2] - got_cyc[1] != 3) begin errors++; $display("FAIL b2b_spacing got %0d %0d exp 3 3", got_cyc[1] - got_cyc[0], got_cyc[2] - got_cyc[1]); end
    checks++; if (got_rd[2] !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rdata_hold got %h exp deadbeef", got_rd[2]); end
  endtask

  task automatic test_contention();
    @(posedge clk); #1; rstn = 1'b0; req = '0;
    @(posedge clk); #1; rstn = 1'b1;
    for (int p = 0; p < NP; p++) set_port(p, 1'b1, 32'h100, 32'h0);
    for (int round = 0; round < 2; round++) begin
      req = 4'b1111;
      run_acks(4, 4'b0000, 60);
      checks++; if (tmo || multi || both) begin errors++; $display("FAIL cont%0d_proto got tmo %b multi %b both %b exp 0 0 0", round, tmo, multi, both); end
      for (int k = 0; k < NP; k++) begin
        checks++; if (got_id[k] != k || got_gid[k] != k) begin errors++; $display("FAIL cont%0d_order[%0d] got ack %0d gid %0d exp %0d", round, k, got_id[k], got_gid[k], k); end
      end
      checks++; if (got_cyc[3] - got_cyc[2] != 4) begin errors++; $display("FAIL cont%0d_rd_spacing got %0d exp 4", round, got_cyc[3] - got_cyc[2]); end
      checks++; if (got_rd[3] !== 32'hDEADBEEF) begin errors++; $display("FAIL cont%0d_rdata got %h exp deadbeef", round, got_rd[3]); end
    end
  endtask

  task automatic test_fairness();
    @(posedge clk); #1;
    set_port(0, 1'b1, 32'h100, 32'h0); set_port(3, 1'b1, 32'h100, 32'h0);
    req = 4'b0001;
    @(posedge clk); #1;
    req[3] = 1'b1;
    run_acks(4, 4'b0001, 60);
    req = '0;
    checks++; if (tmo) begin errors++; $display("FAIL fair_timeout got %0d acks exp 4", n_got); end
    checks++; if (got_id[0] != 0 || got_id[1] != 3 || got_id[2] != 0 || got_id[3] != 0) begin errors++; $display("FAIL fair_order got %0d %0d %0d %0d exp 0 3 0 0", got_id[0], got_id[1], got_id[2], got_id[3]); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    set_port(3, 1'b1, 32'h100, 32'h0); set_port(1, 1'b1, 32'h100, 32'h0);
    req = 4'b1000;
    @(posedge clk); #1;
    checks++; if (sram_read_en !== 1'b1 || grant_id !== 2'd3) begin errors++; $display("FAIL mid_access got ren %b gid %0d exp 1 3", sram_read_en, grant_id); end
    rstn = 1'b0; #1;
    checks++; if (ack !== 4'b0 || busy !== 1'b0 || grant_id !== 2'd0 || sram_read_en !== 1'b0) begin errors++; $display("FAIL mid_rst_ctrl got ack %b busy %b gid %0d ren %b exp 0", ack, busy, grant_id, sram_read_en); end
    checks++; if (sram_addr !== '0 || rdata !== '0) begin errors++; $display("FAIL mid_rst_data got %h %h exp 0 0", sram_addr, rdata); end
    req = 4'b0010;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ack !== 4'b0) begin errors++; $display("FAIL mid_rst_noack got %b exp 0000", ack); end
    @(negedge clk); rstn = 1'b1;
    run_acks(1, 4'b0000, 20);
    checks++; if (tmo || got_id[0] != 1) begin errors++; $display("FAIL mid_after got tmo %b id %0d exp 0 1", tmo, got_id[0]); end
    checks++; if (got_rd[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL mid_rdata got %h exp deadbeef", got_rd[0]); end
  endtask

  task automatic test_wrap();
    @(posedge clk); #1;
    set_port(3, 1'b0, 32'h108, 32'h55); set_port(0, 1'b0, 32'h10C, 32'hAA);
    req = 4'b1000;
    run_acks(1, 4'b0000, 20);
    checks++; if (tmo || got_id[0] != 3) begin errors++; $display("FAIL wrap_first got tmo %b id %0d exp 0 3", tmo, got_id[0]); end
    req = 4'b1001;
    run_acks(2, 4'b0000, 30);
    checks++; if (tmo || got_id[0] != 0 || got_id[1] != 3) begin errors++; $display("FAIL wrap_order got tmo %b %0d %0d exp 0 0 3", tmo, got_id[0], got_id[1]); end
    checks++; if (got_gid[0] != 0 || got_gid[1] != 3) begin errors++; $display("FAIL wrap_gid got %0d %0d exp 0 3", got_gid[0], got_gid[1]); end
    checks++; if (mem[10'h108] !== 32'h55 || mem[10'h10C] !== 32'hAA) begin errors++; $display("FAIL wrap_mem got %h %h exp 55 aa", mem[10'h108], mem[10'h10C]); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_contention();
    test_fairness();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
